// File: rtl/router_pkt_ctrl_if.sv
// Source-side handshake between the packet source and the router input controller.
// The source drives header/payload valid and address bits; the controller answers with busy and drop.
interface router_pkt_ctrl_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       busy;
  logic       drop_pkt;

  modport master (
    output pkt_valid,
    output data_in,
    input  busy,
    input  drop_pkt
  );

  modport slave (
    input  pkt_valid,
    input  data_in,
    output busy,
    output drop_pkt
  );
endinterface

// File: rtl/router_pkt_ctrl.sv
// Packet-sequencing FSM for the 1x3 router input side (header, payload, full stall, parity).
// Optional macro ROUTER_WAIT_TIMEOUT_EN enables the WAIT_TILL_EMPTY abort after WAIT_LIMIT cycles.
module router_pkt_ctrl #(
  parameter int unsigned WAIT_LIMIT = 63
) (
  input  logic              clock,
  input  logic              reset,
  router_pkt_ctrl_if.slave  src,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } state_t;

  if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_bad_wait_limit
    $error("router_pkt_ctrl: WAIT_LIMIT must be within 1..255");
  end

  state_t     state_q;
  state_t     state_d;
  logic [1:0] addr_q;
  logic [1:0] sel_addr;
  logic       tgt_empty;
  logic       soft_hit;
  logic       addr_valid;

  // While decoding, the header on the bus selects the FIFO; afterwards the latched address does.
  always_comb begin
    sel_addr = (state_q == DECODE_ADDRESS) ? src.data_in : addr_q;
    unique case (sel_addr)
      2'b00:   tgt_empty = fifo_empty_0;
      2'b01:   tgt_empty = fifo_empty_1;
      2'b10:   tgt_empty = fifo_empty_2;
      default: tgt_empty = 1'b0;
    endcase
  end

  always_comb begin
    unique case (addr_q)
      2'b00:   soft_hit = soft_reset_0;
      2'b01:   soft_hit = soft_reset_1;
      2'b10:   soft_hit = soft_reset_2;
      default: soft_hit = 1'b0;
    endcase
  end

  assign addr_valid = (src.data_in != 2'b11);

`ifdef ROUTER_WAIT_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       drop_q;
  logic       timeout_fire;
`endif

  // Next-state logic; a soft reset of the addressed port overrides every normal transition.
  always_comb begin
    state_d = state_q;
`ifdef ROUTER_WAIT_TIMEOUT_EN
    timeout_fire = 1'b0;
`endif
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (src.pkt_valid && addr_valid) begin
          state_d = tgt_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          state_d = FIFO_FULL_STATE;
        end else if (!src.pkt_valid) begin
          state_d = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          state_d = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          state_d = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (tgt_empty) begin
          state_d = LOAD_FIRST_DATA;
        end
`ifdef ROUTER_WAIT_TIMEOUT_EN
        else if (wait_cnt_q == 8'(WAIT_LIMIT)) begin
          state_d      = DECODE_ADDRESS;
          timeout_fire = 1'b1;
        end
`endif
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    if (state_q != DECODE_ADDRESS && soft_hit) begin
      state_d = DECODE_ADDRESS;
`ifdef ROUTER_WAIT_TIMEOUT_EN
      timeout_fire = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE_ADDRESS && src.pkt_valid) begin
        addr_q <= src.data_in;
      end
    end
  end

`ifdef ROUTER_WAIT_TIMEOUT_EN
  // The count equals the number of cycles already spent waiting, so the abort lands on cycle WAIT_LIMIT+1.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= 8'd0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= timeout_fire;
      if (state_q == WAIT_TILL_EMPTY && state_d == WAIT_TILL_EMPTY) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end else begin
        wait_cnt_q <= 8'd0;
      end
    end
  end

  assign src.drop_pkt = drop_q;
`else
  assign src.drop_pkt = 1'b0;
`endif

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    src.busy      = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  end

endmodule

// File: doc/router_pkt_ctrl.md
Name: router_pkt_ctrl

Overview:
Packet-sequencing FSM for the 1x3 router input side. It decodes the header address and steps the input register and synchroniser through five phases: header load, payload load, stall on FIFO full, parity load and parity check. It drives the per-phase strobes (detect_add, lfd/ld/laf/full state, write_enb_reg, rst_int_reg) consumed by router_sync and the input register. It also drives busy back to the packet source.

Parameters:
WAIT_LIMIT, 63, cycles allowed in WAIT_TILL_EMPTY before abort. Used only when ROUTER_WAIT_TIMEOUT_EN is defined. Range 1..255.

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; forces DECODE_ADDRESS
pkt_valid  in  1  source has header/payload byte on bus
data_in  in  2  header address bits [1:0]; sampled in DECODE_ADDRESS
fifo_full  in  1  full flag of the currently addressed FIFO (from router_sync)
fifo_empty_0/1/2  in  1 each  empty flags of output FIFOs 0..2
soft_reset_0/1/2  in  1 each  per-port timeout resets (from router_sync)
parity_done  in  1  input register has captured the parity byte
low_pkt_valid  in  1  pkt_valid fell while FIFO was full
detect_add  out  1  high in DECODE_ADDRESS
lfd_state  out  1  high in LOAD_FIRST_DATA
ld_state  out  1  high in LOAD_DATA
laf_state  out  1  high in LOAD_AFTER_FULL
full_state  out  1  high in FIFO_FULL_STATE
write_enb_reg  out  1  high in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL
rst_int_reg  out  1  high in CHECK_PARITY_ERROR
busy  out  1  source must hold its byte
drop_pkt  out  1  one-cycle abort pulse; tied 0 without macro

Behaviour:
- Moore outputs decoded from the state register only. No combinational path from inputs to outputs.
- Reset: state=DECODE_ADDRESS, addr_q=2'b00, wait counter=0. After reset, detect_add=1 and all other outputs are 0.
- addr_q captures data_in on any cycle with state=DECODE_ADDRESS and pkt_valid=1.
- tgt_empty = fifo_empty[data_in] in DECODE_ADDRESS and fifo_empty[addr_q] in all other states. Address 2'b11 is invalid.
- Transitions, evaluated each rising edge:
  - DECODE_ADDRESS:
    - pkt_valid, address valid, tgt_empty -> LOAD_FIRST_DATA.
    - pkt_valid, address valid, !tgt_empty -> WAIT_TILL_EMPTY.
    - Otherwise stay; an address of 11 is ignored with busy=0.
  - LOAD_FIRST_DATA -> LOAD_DATA (1 cycle, always).
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - else !pkt_valid -> LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_pkt_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR (1 cycle).
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: tgt_empty -> LOAD_FIRST_DATA; else stay.
- busy:
  - 1 in LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
  - 0 in DECODE_ADDRESS and LOAD_DATA.
- Priority: reset > soft reset > normal transition.
- Soft reset: soft_reset_[addr_q]=1 in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next edge. Soft resets of non-addressed ports are ignored. In DECODE_ADDRESS soft resets have no effect.
- Reset mid-packet returns to DECODE_ADDRESS next edge regardless of other inputs. addr_q is cleared.
- Back-to-back packets: DECODE_ADDRESS is entered from CHECK_PARITY_ERROR. A header present in that cycle is decoded with a 1-cycle bubble.

Optional Feature:
ROUTER_WAIT_TIMEOUT_EN
- Defined:
  - An 8-bit counter increments each cycle in WAIT_TILL_EMPTY and clears on any other state.
  - When count==WAIT_LIMIT and !tgt_empty: state -> DECODE_ADDRESS, drop_pkt=1 for exactly one cycle (registered), counter -> 0.
  - tgt_empty on the same edge wins over the timeout (-> LOAD_FIRST_DATA, no drop).
- Undefined: no counter, drop_pkt constant 0, WAIT_TILL_EMPTY waits indefinitely.

Test Plan:
1. Reset=1 for 2 cycles with pkt_valid=1 -> detect_add=1, busy=0, all other strobes 0 after release.
2. Header addr=01 with fifo_empty_1=1, 5 payload cycles, then pkt_valid=0 -> states DECODE, LFD (1), LD (5), LOAD_PARITY, CHECK_PARITY, DECODE. rst_int_reg high exactly 1 cycle.
3. addr=10, fifo_full=1 on payload cycle 3 for 4 cycles -> full_state high 4 cycles, then laf_state 1 cycle, then ld_state resumes. write_enb_reg=0 while full.
4. addr=00 with fifo_empty_0=0 for 10 cycles -> WAIT_TILL_EMPTY, busy=1 for 10 cycles, LOAD_FIRST_DATA on the cycle after empty rises.
5. soft_reset_2 pulse mid-LOAD_DATA for addr=10 -> DECODE_ADDRESS next edge. soft_reset_0 pulse in the same packet -> no effect.
6. With ROUTER_WAIT_TIMEOUT_EN and WAIT_LIMIT=4: addr=01, fifo_empty_1 held 0 -> drop_pkt high exactly 1 cycle after 5 cycles in WAIT_TILL_EMPTY, state returns to DECODE_ADDRESS. Header with addr=11 -> no state change.
